matmul_ctrl_param: RTL
======================

# matmul_ctrl_param

Parametrised control FSM for the NxN matrix-multiplication datapath; successor to the fixed 3x3 controller. It sequences four phases: loading A and B into the input memory, computing each result element as an N-term multiply-accumulate, writing results to the output memory, and draining those results in PARTS slices. Both the load and drain phases can be skipped, and a busy flag is provided. It drives the existing input memory, A/B operand registers, result accumulator and output memory.

## Interface
- N, default 3: matrix dimension, N ≥ 2.
- PARTS, default 3: readout slices per result word, ≥ 1.
- AW, default $clog2(2*N*N): input-memory address width.
- OW, default $clog2(N*N): output-memory address width.
- PW, default (PARTS>1 ? $clog2(PARTS) : 1): part-select width.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- st  input  1  start; a run is armed on high and launched on the following low.
- load_en  input  1  1: run LOAD phase; sampled on ARM exit.
- drain_en  input  1  1: run DRAIN phase; sampled on ARM exit.
- memin_read, memin_write  output  1  input-memory strobes.
- Awrite, Bwrite  output  1  operand-register load strobes.
- Reswrite  output  1  accumulator update (acc += A*B).
- clearRes  output  1  accumulator clear.
- memout_write, memout_read  output  1  output-memory strobes.
- done  output  1  one-cycle end-of-compute pulse.
- busy  output  1  high in every state except IDLE.
- addr  output  AW  input-memory address.
- addr_out  output  OW  output-memory address.
- part  output  PW  readout slice index.

## Operation
- Outputs are Moore-decoded from the registered state and counters. Every output is 0 unless listed for the current state.
- Counters:
  - ld: 0..2N²-1.
  - i, j, k: 0..N-1 each.
  - dr: 0..N²·PARTS-1.
- Memory layout: A[i][k] is at address i·N+k; B[k][j] is at address N²+k·N+j; C[i][j] is at output address i·N+j.
- IDLE:
  - Outputs: all 0.
  - Transitions: st=1 → ARM.
- ARM:
  - Outputs: busy, clearRes.
  - Transitions: st=0 → LOAD if load_en=1, otherwise → RDA.
  - On exit: latch load_en and drain_en; zero all counters.
- LOAD:
  - Outputs: memin_write, addr=ld.
  - Transitions: ld = 2N²-1 → RDA (ld cleared); otherwise ld+1.
- RDA:
  - Outputs: memin_read, Awrite, addr=i·N+k.
  - Transitions: → RDB.
- RDB:
  - Outputs: memin_read, Bwrite, addr=N²+k·N+j.
  - Transitions: → MAC.
- MAC:
  - Outputs: Reswrite.
  - Transitions: k = N-1 → WRES (k cleared); otherwise k+1 and → RDA.
- WRES:
  - Outputs: memout_write, addr_out=i·N+j.
  - Transitions: → CLR.
- CLR:
  - Outputs: clearRes.
  - Transitions: if (i,j) = (N-1,N-1) → DONE; otherwise advance j and → RDA, with j wrapping to 0 and incrementing i.
- DONE:
  - Outputs: done.
  - Transitions: → DRAIN if drain_en latched, otherwise → IDLE.
- DRAIN:
  - Outputs: memout_read, addr_out=dr/PARTS, part=dr%PARTS.
  - Transitions: dr = N²·PARTS-1 → IDLE; otherwise dr+1.
- Any unused state encoding → IDLE.
- st is ignored outside IDLE and ARM. Holding st high keeps the FSM in ARM indefinitely.
- load_en and drain_en changes after ARM exit have no effect on the current run.

## Timing
- Reset: rst=0 at a clk edge forces IDLE, zeroes all counters and latched modes, and drives every output to 0. This applies in any state, including mid-LOAD and mid-DRAIN, and is a full abort. The next run must re-arm through IDLE → ARM. Reset dominates st.
- Phase lengths, counted in cycles after leaving ARM:
  - LOAD: 2N².
  - Compute: N²·(3N+2).
  - DONE: 1.
  - DRAIN: N²·PARTS.
- N=3, PARTS=3, both phases enabled: 18 + 99 + 1 + 27 = 145 cycles, then IDLE.
- Between consecutive results: memout_write of C[i][j] precedes the RDA of the next element by exactly 2 cycles (the CLR cycle lies between them).
- Back-to-back runs: from IDLE, the earliest next ARM is 1 cycle after entering IDLE.

## Test plan
- Load, N=3: pulse st high 1 cycle then low with load_en=1 → 18 consecutive memin_write cycles with addr 0..17, then RDA with addr=0.
- First element, N=3: during compute of C[0][0], A addrs are 0,1,2 and B addrs are 9,12,15; exactly 3 Reswrite pulses; then memout_write with addr_out=0, then one clearRes cycle.
- Full run, N=3, PARTS=3: done is high for exactly 1 cycle, 117 cycles after the LOAD start. Drain then produces (addr_out, part) = (0,0),(0,1),(0,2),(1,0)…(8,2), then IDLE with busy=0.
- Parametric, N=2, PARTS=1, load_en=0, drain_en=0: no memin_write; 4 memout_write pulses at addr_out 0,1,2,3; compute lasts 4·8=32 cycles; done pulse, then IDLE.
- Reset mid-compute: drive rst=0 during MAC of C[1][2] → next cycle is IDLE, all outputs 0. A re-armed run starts again from ld=0.
- st stuck high for 10 cycles → FSM stays in ARM with busy=1, clearRes=1 and no memory strobes. LOAD begins the cycle after st falls.

Source files
------------

// File: rtl/matmul_ctrl_param.sv
// Sequencer for an NxN matrix-multiply datapath: optional load of A/B,
// N-term multiply-accumulate per result element, result write-back and
// optional sliced drain of the output memory.
module matmul_ctrl_param #(
    parameter int N     = 3,
    parameter int PARTS = 3,
    parameter int AW    = $clog2(2*N*N),
    parameter int OW    = $clog2(N*N),
    parameter int PW    = (PARTS > 1 ? $clog2(PARTS) : 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st,
    input  logic          load_en,
    input  logic          drain_en,
    output logic          memin_read,
    output logic          memin_write,
    output logic          Awrite,
    output logic          Bwrite,
    output logic          Reswrite,
    output logic          clearRes,
    output logic          memout_write,
    output logic          memout_read,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic [OW-1:0] addr_out,
    output logic [PW-1:0] part
);

    localparam int CW = $clog2(N);
    localparam int DW = $clog2(N*N*PARTS);

    localparam logic [AW-1:0] LD_LAST = AW'(2*N*N - 1);
    localparam logic [CW-1:0] IX_LAST = CW'(N - 1);
    localparam logic [DW-1:0] DR_LAST = DW'(N*N*PARTS - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ARM   = 4'd1,
        S_LOAD  = 4'd2,
        S_RDA   = 4'd3,
        S_RDB   = 4'd4,
        S_MAC   = 4'd5,
        S_WRES  = 4'd6,
        S_CLR   = 4'd7,
        S_DONE  = 4'd8,
        S_DRAIN = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ld_q, ld_d;
    logic [CW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0]   dr_q, dr_d;
    logic            drain_q, drain_d;

    // State, counters and latched drain mode; reset aborts any run
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ld_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            dr_q    <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            dr_q    <= dr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        dr_d    = dr_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: if (st) state_d = S_ARM;
            // load_en only steers this exit, so it is consumed here rather than stored
            S_ARM: begin
                if (!st) begin
                    state_d = load_en ? S_LOAD : S_RDA;
                    drain_d = drain_en;
                    ld_d    = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    dr_d    = '0;
                end
            end
            S_LOAD: begin
                if (ld_q == LD_LAST) begin
                    ld_d    = '0;
                    state_d = S_RDA;
                end else begin
                    ld_d = ld_q + AW'(1);
                end
            end
            S_RDA: state_d = S_RDB;
            S_RDB: state_d = S_MAC;
            S_MAC: begin
                if (k_q == IX_LAST) begin
                    k_d     = '0;
                    state_d = S_WRES;
                end else begin
                    k_d     = k_q + CW'(1);
                    state_d = S_RDA;
                end
            end
            S_WRES: state_d = S_CLR;
            S_CLR: begin
                if (i_q == IX_LAST && j_q == IX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RDA;
                    if (j_q == IX_LAST) begin
                        j_d = '0;
                        i_d = i_q + CW'(1);
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
            end
            S_DONE: state_d = drain_q ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (dr_q == DR_LAST) begin
                    dr_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    dr_d = dr_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from registered state and counters
    always_comb begin
        memin_read   = 1'b0;
        memin_write  = 1'b0;
        Awrite       = 1'b0;
        Bwrite       = 1'b0;
        Reswrite     = 1'b0;
        clearRes     = 1'b0;
        memout_write = 1'b0;
        memout_read  = 1'b0;
        done         = 1'b0;
        busy         = (state_q != S_IDLE);
        addr         = '0;
        addr_out     = '0;
        part         = '0;
        unique case (state_q)
            S_ARM:  clearRes = 1'b1;
            S_LOAD: begin
                memin_write = 1'b1;
                addr        = ld_q;
            end
            S_RDA: begin
                memin_read = 1'b1;
                Awrite     = 1'b1;
                addr       = AW'(int'(i_q) * N + int'(k_q));
            end
            S_RDB: begin
                memin_read = 1'b1;
                Bwrite     = 1'b1;
                addr       = AW'(N * N + int'(k_q) * N + int'(j_q));
            end
            S_MAC:  Reswrite = 1'b1;
            S_WRES: begin
                memout_write = 1'b1;
                addr_out     = OW'(int'(i_q) * N + int'(j_q));
            end
            S_CLR:  clearRes = 1'b1;
            S_DONE: done = 1'b1;
            S_DRAIN: begin
                memout_read = 1'b1;
                addr_out    = OW'(int'(dr_q) / PARTS);
                part        = PW'(int'(dr_q) % PARTS);
            end
            default: busy = 1'b0;
        endcase
    end

endmodule
